// File: rtl/weight_bus_pkg.sv
// Shared types and constants for the weight-buffer bus.
// Used by the weight read master.
package weight_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  localparam int ARBURST_W = 4;
  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 32;

endpackage

// File: rtl/weight_rd_master.sv
// Weight-buffer bus read master: one burst in flight,
// returned beats written to the local buffer one cycle later.
module weight_rd_master
  import weight_bus_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int BURST_LOG2 = 3,
  parameter int BUF_AW     = 10,
  parameter int NB_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [NB_W-1:0]       cmd_nburst,
  input  logic [BUF_AW-1:0]     cmd_buf_addr,
  output logic [AW-1:0]         araddr,
  output logic                  arvalid,
  output logic [ARBURST_W-1:0]  arburst,
  input  logic                  arready,
  input  logic [DW-1:0]         rdata,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  buf_we,
  output logic [BUF_AW-1:0]     buf_waddr,
  output logic [DW-1:0]         buf_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BEATS = 1 << BURST_LOG2;
  localparam int BW    = BURST_LOG2 + 1;

  localparam logic [BW-1:0]     BEAT_END  = BW'(BEATS);
  localparam logic [BW-1:0]     BEAT_LAST = BW'(BEATS - 1);
  localparam logic [AW-1:0]     ADDR_STEP = AW'(BEATS);
  localparam logic [BUF_AW-1:0] BUF_STEP  = BUF_AW'(BEATS);

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [BUF_AW-1:0]   base_q, base_d;
  logic [NB_W-1:0]     rem_q, rem_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [BUF_AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]       wdata_q, wdata_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, burst bookkeeping and buffer write stage
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          base_d  = cmd_buf_addr;
          rem_d   = cmd_nburst;
          err_d   = 1'b0;
          state_d = (cmd_nburst == '0) ? S_DONE : S_ADDR;
        end
        if (rvalid) err_d = 1'b1;
      end
      S_ADDR: begin
        if (arready) begin
          state_d = S_DATA;
          beat_d  = '0;
          rem_d   = rem_q - 1'b1;
        end
        if (rvalid) err_d = 1'b1;
      end
      S_DATA: begin
        if (rvalid) begin
          // Beats past the burst length are dropped
          if (beat_q != BEAT_END) begin
            we_d    = 1'b1;
            waddr_d = base_q + BUF_AW'(beat_q);
            wdata_d = rdata;
            beat_d  = beat_q + 1'b1;
            if (beat_q == BEAT_LAST && !rlast) err_d = 1'b1;
          end
          if (rlast) begin
            if (beat_q != BEAT_LAST) err_d = 1'b1;
            addr_d  = addr_q + ADDR_STEP;
            base_d  = base_q + BUF_STEP;
            state_d = (rem_q != '0) ? S_ADDR : S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (rvalid) err_d = 1'b1;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign arvalid   = (state_q == S_ADDR);
  assign araddr    = addr_q;
  assign arburst   = ARBURST_W'(BURST_LOG2);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign buf_we    = we_q;
  assign buf_waddr = waddr_q;
  assign buf_wdata = wdata_q;

endmodule

// File: tb/tb_weight_rd_master.sv
// Bench for weight_rd_master: table vectors, random commands
// and hand sequences against a burst/write reference model.
module tb_weight_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_nburst;
  logic [9:0]  cmd_buf_addr;
  logic [31:0] araddr;
  logic        arvalid;
  logic [3:0]  arburst;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        buf_we;
  logic [9:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  weight_rd_master dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_nburst   (cmd_nburst),
    .cmd_buf_addr (cmd_buf_addr),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arburst      (arburst),
    .arready      (arready),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rlast        (rlast),
    .buf_we       (buf_we),
    .buf_waddr    (buf_waddr),
    .buf_wdata    (buf_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Observed traffic
  logic [41:0] wq[$];
  logic [31:0] arq[$];
  int          done_cnt;
  int          arv_cycles;

  always @(negedge clk) begin
    if (buf_we) wq.push_back({buf_waddr, buf_wdata});
    if (arvalid && arready) arq.push_back(araddr);
    if (arvalid) arv_cycles++;
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and play the responder. nb0 is the beat
  // count of the first burst (8 = well formed); later bursts are 8.
  task automatic run_cmd(input string tag, input logic [31:0] a,
                         input int nb, input logic [9:0] b,
                         input int ardly, input int nb0,
                         input bit exp_err, input bit rnd);
    logic [41:0] ew[$];
    logic [31:0] ea[$];
    logic [31:0] cur;
    logic [9:0]  bb;
    logic [31:0] d;
    int          t;
    int          n;
    int          bad;
    wq.delete();
    arq.delete();
    done_cnt   = 0;
    arv_cycles = 0;
    t = 0;
    while (!cmd_ready && t < 50) begin
      step();
      t++;
    end
    check({tag, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid    = 1'b1;
    cmd_addr     = a;
    cmd_nburst   = 16'(nb);
    cmd_buf_addr = b;
    step();
    cmd_valid = 1'b0;
    check({tag, "/err_clr"}, 64'(err), 64'd0);
    if (nb == 0) begin
      check({tag, "/done_t1"}, 64'(done), 64'd1);
      check({tag, "/no_arv"}, 64'(arvalid), 64'd0);
    end else begin
      check({tag, "/arv_t1"}, 64'(arvalid), 64'd1);
      for (int k = 0; k < nb; k++) begin
        cur = a + 32'(k * 8);
        bb  = b + 10'(k * 8);
        t = 0;
        while (!arvalid && t < 50) begin
          step();
          t++;
        end
        check({tag, "/arvalid"}, 64'(arvalid), 64'd1);
        check({tag, "/araddr"}, 64'(araddr), 64'(cur));
        ea.push_back(cur);
        for (int w = 0; w < ardly; w++) begin
          step();
          check({tag, "/ar_hold"}, {31'd0, arvalid, araddr},
                {31'd0, 1'b1, cur});
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        n = (k == 0) ? nb0 : 8;
        for (int i = 0; i < n; i++) begin
          d = rnd ? $urandom : cur + 32'(i);
          rvalid = 1'b1;
          rdata  = d;
          rlast  = (i == n - 1);
          if (i < 8) ew.push_back({bb + 10'(i), d});
          step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        if (n <= 8) check({tag, "/last_we"}, 64'(buf_we), 64'd1);
        if (k < nb - 1)
          check({tag, "/next_arv"}, 64'(arvalid), 64'd1);
        else
          check({tag, "/done_l1"}, 64'(done), 64'd1);
      end
    end
    step();
    check({tag, "/done_pulse"}, 64'(done), 64'd0);
    check({tag, "/ready_l2"}, 64'(cmd_ready), 64'd1);
    check({tag, "/err"}, 64'(err), 64'(exp_err));
    check({tag, "/done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "/ar_cnt"}, 64'(arq.size()), 64'(ea.size()));
    if (nb == 0) check({tag, "/arv_cyc"}, 64'(arv_cycles), 64'd0);
    check({tag, "/wr_cnt"}, 64'(wq.size()), 64'(ew.size()));
    bad = 0;
    for (int i = 0; i < ew.size(); i++)
      if (i >= wq.size() || wq[i] !== ew[i]) bad++;
    for (int i = 0; i < ea.size(); i++)
      if (i >= arq.size() || arq[i] !== ea[i]) bad++;
    check({tag, "/contents"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          nb;
    logic [9:0]  bufa;
    int          ardly;
    int          nb0;
    bit          exp_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int nb0;
    int r;
    tbl[0] = '{32'h40,       1, 10'd0,    0, 8,  1'b0};
    tbl[1] = '{32'h100,      3, 10'h20,   5, 8,  1'b0};
    tbl[2] = '{32'h80,       0, 10'd5,    0, 8,  1'b0};
    tbl[3] = '{32'h200,      2, 10'h10,   1, 6,  1'b1};
    tbl[4] = '{32'h300,      1, 10'd1020, 0, 8,  1'b0};
    tbl[5] = '{32'h400,      1, 10'd0,    2, 10, 1'b1};
    tbl[6] = '{32'hFFFFFFF8, 2, 10'd3,    0, 8,  1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_nburst = '0;
    cmd_buf_addr = '0;
    arready = 1'b0;
    rdata = '0;
    rvalid = 1'b0;
    rlast = 1'b0;
    step();
    step();
    check("rst/cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst/outs", {araddr, arvalid, buf_we, busy, done, err},
          64'd0);
    check("rst/wport", {buf_waddr, buf_wdata}, 64'd0);
    check("rst/arburst", 64'(arburst), 64'd3);
    rst = 1'b0;
    step();
    check("rst/ready_after", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 7; i++)
      run_cmd($sformatf("vec%0d", i), tbl[i].addr, tbl[i].nb,
              tbl[i].bufa, tbl[i].ardly, tbl[i].nb0,
              tbl[i].exp_err, 1'b0);

    // Reset while the fourth beat of a burst is on the bus
    cmd_valid = 1'b1;
    cmd_addr = 32'h500;
    cmd_nburst = 16'd1;
    cmd_buf_addr = 10'd0;
    step();
    cmd_valid = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1;
      rdata = 32'h500 + 32'(i);
      step();
    end
    rdata = 32'h503;
    rst = 1'b1;
    step();
    rvalid = 1'b0;
    check("mrst/outs", {arvalid, buf_we, busy, done, err}, 64'd0);
    check("mrst/ready_in_rst", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (4) step();
    check("mrst/no_done", 64'(done_cnt), 64'd0);
    check("mrst/idle", {cmd_ready, busy}, 64'd2);
    run_cmd("mrst/fresh", 32'h600, 1, 10'd100, 1, 8, 1'b0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      nb = $urandom_range(0, 3);
      r  = $urandom_range(0, 3);
      if (r < 2) nb0 = 8;
      else if (r == 2) nb0 = $urandom_range(1, 7);
      else nb0 = $urandom_range(9, 11);
      run_cmd($sformatf("rnd%0d", it), $urandom, nb,
              10'($urandom), $urandom_range(0, 3), nb0,
              (nb > 0) && (nb0 != 8), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_rd_master.md
# weight_rd_master

Read-side initiator on the weight-buffer bus. It accepts a fetch command (source word address, burst count, destination buffer address) and issues one burst read request at a time. Returned beats are written into the local weight buffer through a registered write port, and completion or error is reported to the layer controller.

## Interface
- DW, 32: data width of bus and buffer words
- AW, 32: bus word-address width
- BURST_LOG2, 3: log2 of beats per burst; driven on arburst (value 0..15)
- BUF_AW, 10: weight-buffer address width
- NB_W, 16: width of burst-count field
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  fetch command present
- cmd_ready  out  1  high only in IDLE; accept on cmd_valid & cmd_ready
- cmd_addr  in  AW  first bus word address
- cmd_nburst  in  NB_W  number of bursts to fetch (0 legal)
- cmd_buf_addr  in  BUF_AW  first buffer write address
- araddr  out  AW  burst start word address
- arvalid  out  1  request valid, held until arready
- arburst  out  4  constant BURST_LOG2; burst = 2^arburst beats
- arready  in  1  responder accepts request
- rdata  in  DW  returned beat
- rvalid  in  1  beat valid; no back-pressure, must be taken every cycle
- rlast  in  1  final beat of burst
- buf_we, buf_waddr[BUF_AW], buf_wdata[DW]  out  buffer write port
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky protocol error, cleared on next command accept

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: cmd_ready=1. On accept, latch cmd_addr, cmd_buf_addr, remaining=cmd_nburst; clear err. If cmd_nburst==0 -> DONE, else -> ADDR.
- ADDR: arvalid=1, araddr=current address. On arvalid&arready -> DATA; beat counter=0, remaining decremented.
- DATA: each rvalid beat writes rdata to buffer; write address = burst buffer base + beat counter. On rvalid&rlast: advance address by 2^BURST_LOG2 (mod 2^AW) and buffer base by 2^BURST_LOG2 (mod 2^BUF_AW); remaining>0 -> ADDR, else -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Beat accounting: if rlast arrives with beat counter != 2^BURST_LOG2-1 (early), set err; the burst still ends. If counter reaches 2^BURST_LOG2 without rlast (late), set err; further beats are dropped (no write) until rlast.
- rvalid outside DATA: beat dropped, err set.
- arready outside ADDR: ignored.
- Only one burst is outstanding at a time.

## Timing
- Reset values: cmd_ready=0 during rst, 1 the cycle after. arvalid=0, araddr=0, buf_we=0, buf_waddr=0, buf_wdata=0, busy=0, done=0, err=0. arburst is constant.
- Accept at cycle T: arvalid=1 at T+1.
- arvalid/araddr stay stable while arready=0.
- Handshake at cycle H: DATA from H+1. A beat at H+1 is legal and must be captured.
- Write latency: beat at cycle B produces buf_we=1 with matching buf_waddr/buf_wdata at B+1. Back-to-back beats give back-to-back writes.
- rlast of final burst at cycle L: last write at L+1, done=1 at L+1, cmd_ready=1 at L+2.
- Next burst: rlast at L -> arvalid=1 at L+1.
- cmd_nburst=0 accepted at T: done at T+1, no arvalid ever.
- rst mid-operation: return to IDLE next cycle; outputs take reset values; in-flight beats ignored; no done.

## Structure
- Package weight_bus_pkg: state enum (IDLE/ADDR/DATA/DONE), arburst width constant 4, default DW/AW.
- Single module with no sub-modules. The write-port register stage is simple enough to stay inline.

## Test plan
- Single burst: cmd_addr=0x40, nburst=1, buf=0, arready immediate, 8 beats 0x40..0x47 -> writes addr 0..7 data 0x40..0x47, done one cycle after rlast, err=0.
- Three bursts, arready held low 5 cycles each -> araddr 0x100, 0x108, 0x110, each stable while waiting; 24 contiguous writes; one done pulse.
- nburst=0 -> done at T+1, arvalid never asserted, no buf_we.
- Early rlast on beat 5 -> err=1, 6 writes, next burst issued normally. New command clears err.
- Buffer wrap: cmd_buf_addr=1020, nburst=1 -> writes 1020..1023 then 0..3.
- rst asserted during DATA at beat 3 -> next cycle IDLE, arvalid=0, buf_we=0, no done. Fresh command completes correctly.
